// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between a single-word
// CPU port (A) and a burst loader port (B); read data returns one cycle later.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [LW-1:0] b_len,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic          prio_b;
  logic [AW-1:0] base;
  logic [LW-1:0] beat, last;
  logic          bwe;

  logic a_win, b_win, burst_go, b_rd;

  // Grants are gated by reset so nothing reaches memory while it is held.
  always_comb begin
    a_win    = 1'b0;
    b_win    = 1'b0;
    burst_go = 1'b0;
    if (!reset && state == IDLE) begin
      a_win = a_req & (~b_req | ~prio_b);
      b_win = b_req & (~a_req |  prio_b);
    end
    if (!reset && state == BURST) burst_go = b_req;
    a_gnt   = a_win;
    b_gnt   = b_win | burst_go;
    dm_addr = a_addr;
    dm_din  = a_wdata;
    dm_we   = 1'b0;
    b_rd    = ~bwe;
    if (a_win) begin
      dm_we = a_we;
    end else if (b_win) begin
      dm_addr = b_addr;
      dm_din  = b_wdata;
      dm_we   = b_we;
      b_rd    = ~b_we;
    end else if (state == BURST) begin
      dm_addr = base + AW'(beat);
      dm_din  = b_wdata;
      dm_we   = burst_go & bwe;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prio_b   <= 1'b0;
      base     <= '0;
      beat     <= '0;
      last     <= '0;
      bwe      <= 1'b0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_done   <= 1'b0;
    end else begin
      a_rvalid <= a_win & ~a_we;
      if (a_win & ~a_we) a_rdata <= dm_dout;
      b_rvalid <= b_gnt & b_rd;
      if (b_gnt & b_rd) b_rdata <= dm_dout;
      b_done <= 1'b0;
      if (a_win) begin
        prio_b <= 1'b1;
      end else if (b_win) begin
        base <= b_addr;
        last <= b_len;
        bwe  <= b_we;
        beat <= LW'(1);
        if (b_len == '0) begin
          b_done <= 1'b1;
          prio_b <= 1'b0;
        end else begin
          state <= BURST;
        end
      end else if (state == BURST) begin
        if (b_req) begin
          beat <= beat + LW'(1);
          if (beat == last) begin
            state  <= IDLE;
            prio_b <= 1'b0;
            b_done <= 1'b1;
          end
        end else begin
          // Requester withdrew mid-burst: abandon it silently.
          state  <= IDLE;
          prio_b <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024x32 memory attached.
module tb_dm_arbiter;
  logic        clk, reset;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_done;
  logic [9:0]  b_addr;
  logic [3:0]  b_len;
  logic [31:0] b_wdata, b_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we;

  logic [31:0] mem [0:1023];
  int nvec = 0;
  int nerr = 0;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;
  assign dm_dout = mem[dm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_len = 0; b_wdata = 0;
    cyc(); cyc();
    // requests while reset is held must not be granted
    a_req = 1; a_we = 1; b_req = 1; b_we = 1;
    #1;
    chk("rst a_gnt", a_gnt, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst dm_we", dm_we, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_done", b_done, 0);
    chk("rst a_rdata", a_rdata, 0);
    a_req = 0; b_req = 0;
    cyc();
    reset = 0;

    // T1: A write then read of addr 5
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 32'h12345678;
    #1;
    chk("t1 wr a_gnt", a_gnt, 1);
    chk("t1 wr dm_we", dm_we, 1);
    chk("t1 wr dm_addr", dm_addr, 5);
    cyc();
    chk("t1 wr no rvalid", a_rvalid, 0);
    a_we = 0;
    #1;
    chk("t1 rd a_gnt", a_gnt, 1);
    chk("t1 rd dm_we", dm_we, 0);
    cyc();
    chk("t1 a_rvalid", a_rvalid, 1);
    chk("t1 a_rdata", a_rdata, 32'h12345678);
    a_req = 0;

    // T2: fresh reset, simultaneous requests -> A first, then alternate
    reset = 1; #1; reset = 0;
    a_req = 1; a_we = 0; a_addr = 5;
    b_req = 1; b_we = 0; b_addr = 5; b_len = 0;
    #1;
    chk("t2 first a_gnt", a_gnt, 1);
    chk("t2 first b_gnt", b_gnt, 0);
    cyc();
    chk("t2 a_rvalid", a_rvalid, 1);
    #1;
    chk("t2 second b_gnt", b_gnt, 1);
    chk("t2 second a_gnt", a_gnt, 0);
    cyc();
    chk("t2 b_rvalid", b_rvalid, 1);
    chk("t2 b_rdata", b_rdata, 32'h12345678);
    chk("t2 b_done", b_done, 1);
    chk("t2 a_rvalid low", a_rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2 alt a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
      chk("t2 alt b_gnt", b_gnt, (i % 2 == 1) ? 1 : 0);
      cyc();
    end
    a_req = 0; b_req = 0;
    cyc();

    // T3: A-only grant hands priority to B, then wrapping write burst
    a_req = 1; a_we = 0; a_addr = 5;
    #1;
    chk("t3 pre a_gnt", a_gnt, 1);
    cyc();
    chk("t3 pre a_rvalid", a_rvalid, 1);
    b_req = 1; b_we = 1; b_addr = 10'd1022; b_len = 3;
    for (int i = 0; i < 4; i++) begin
      b_wdata = 32'hA0 + i;
      #1;
      chk("t3 b_gnt", b_gnt, 1);
      chk("t3 a_gnt", a_gnt, 0);
      chk("t3 dm_addr", dm_addr, (1022 + i) % 1024);
      chk("t3 dm_we", dm_we, 1);
      chk("t3 dm_din", dm_din, 32'hA0 + i);
      cyc();
      if (i < 3) chk("t3 b_done early", b_done, 0);
    end
    chk("t3 b_done", b_done, 1);
    b_req = 0;
    #1;
    chk("t3 a_gnt after", a_gnt, 1);
    cyc();
    a_req = 0;
    chk("t3 a_rvalid after", a_rvalid, 1);
    chk("t3 a_rdata after", a_rdata, 32'h12345678);

    // T4: read back the same four words
    b_req = 1; b_we = 0; b_addr = 10'd1022; b_len = 3; b_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4 b_gnt", b_gnt, 1);
      chk("t4 dm_we", dm_we, 0);
      cyc();
      chk("t4 b_rvalid", b_rvalid, 1);
      chk("t4 b_rdata", b_rdata, 32'hA0 + i);
    end
    chk("t4 b_done", b_done, 1);
    b_req = 0;
    cyc();
    chk("t4 b_rvalid end", b_rvalid, 0);

    // T5: len-8 write burst abandoned after beat 2
    b_req = 1; b_we = 1; b_addr = 100; b_len = 7;
    for (int i = 0; i < 3; i++) begin
      b_wdata = 32'hB0 + i;
      #1;
      chk("t5 b_gnt", b_gnt, 1);
      cyc();
    end
    b_req = 0; a_req = 1; a_we = 0; a_addr = 5;
    #1;
    chk("t5 abort b_gnt", b_gnt, 0);
    chk("t5 abort dm_we", dm_we, 0);
    chk("t5 abort a_gnt", a_gnt, 0);
    cyc();
    chk("t5 b_done", b_done, 0);
    #1;
    chk("t5 idle a_gnt", a_gnt, 1);
    cyc();
    chk("t5 b_done late", b_done, 0);
    a_req = 0;
    for (int i = 0; i < 8; i++)
      chk("t5 mem", mem[100 + i], (i < 3) ? 32'hB0 + i : 32'h0);

    // T6: asynchronous reset during beat 2 of an 8-beat write burst
    b_req = 1; b_we = 1; b_addr = 200; b_len = 7;
    for (int i = 0; i < 2; i++) begin
      b_wdata = 32'hC0 + i;
      #1;
      chk("t6 b_gnt", b_gnt, 1);
      cyc();
    end
    b_wdata = 32'hC2;
    #1;
    chk("t6 beat2 dm_we", dm_we, 1);
    reset = 1;
    #1;
    chk("t6 rst b_gnt", b_gnt, 0);
    chk("t6 rst dm_we", dm_we, 0);
    chk("t6 rst b_done", b_done, 0);
    cyc();
    chk("t6 held b_gnt", b_gnt, 0);
    reset = 0;
    a_req = 1; a_we = 0; a_addr = 5;
    b_req = 1; b_we = 0; b_addr = 5; b_len = 0;
    #1;
    chk("t6 post a_gnt", a_gnt, 1);
    chk("t6 post b_gnt", b_gnt, 0);
    chk("t6 post b_done", b_done, 0);
    cyc();
    chk("t6 b_done none", b_done, 0);
    chk("t6 a_rvalid", a_rvalid, 1);
    chk("t6 mem beat1", mem[201], 32'hC1);
    chk("t6 mem beat2", mem[202], 32'h0);
    #1;
    chk("t6 then b_gnt", b_gnt, 1);
    a_req = 0; b_req = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
